// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK/NACK, STOP.
// Open-drain scl/sda are only ever pulled low; the bus pull-ups provide the high level.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       iw_clk,
    input  logic       iw_reset,
    input  logic       iw_start,
    input  logic       iw_rw,
    input  logic [6:0] iw_addr,
    input  logic [7:0] iw_wdata,
    output logic       or_busy,
    output logic       or_done,
    output logic [7:0] or_rdata,
    output logic       or_nack,
    inout  wire        scl,
    inout  wire        sda
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_STOP
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_div;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_wbyte;
    logic [7:0] r_rx;
    logic       r_rw;
    logic       r_ack;

    logic       w_tick;
    logic       w_last_q;
    logic       w_accept;
    logic       w_scl_lo;
    logic       w_sda_lo;
    logic       w_sda_in;

    assign w_tick   = or_busy && (r_div == DIV_LAST);
    assign w_last_q = w_tick && (r_q == 2'd3);
    assign w_accept = (r_state == S_IDLE) && iw_start;
    assign w_sda_in = sda;

    assign scl = w_scl_lo ? 1'b0 : 1'bz;
    assign sda = w_sda_lo ? 1'b0 : 1'bz;

    always_ff @(posedge iw_clk or posedge iw_reset) begin
        if (iw_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus levels are decoded from state/quarter so a reset releases both lines at once.
    always_comb begin
        w_state_nxt = r_state;
        w_scl_lo    = 1'b0;
        w_sda_lo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iw_start) w_state_nxt = S_START;
            end
            S_START: begin
                w_sda_lo = r_q[1];
                if (w_last_q) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_scl_lo = ~r_q[1];
                w_sda_lo = ~r_shift[7];
                if (w_last_q && (r_bit == 3'd7)) w_state_nxt = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                w_scl_lo = ~r_q[1];
                if (w_last_q) begin
                    if (r_ack)     w_state_nxt = S_STOP;
                    else if (r_rw) w_state_nxt = S_RD_DATA;
                    else           w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                w_scl_lo = ~r_q[1];
                w_sda_lo = ~r_wbyte[7];
                if (w_last_q && (r_bit == 3'd7)) w_state_nxt = S_WR_ACK;
            end
            S_WR_ACK: begin
                w_scl_lo = ~r_q[1];
                if (w_last_q) w_state_nxt = S_STOP;
            end
            S_RD_DATA: begin
                w_scl_lo = ~r_q[1];
                if (w_last_q && (r_bit == 3'd7)) w_state_nxt = S_RD_ACK;
            end
            S_RD_ACK: begin
                // sda left released: single-byte read always ends with NACK
                w_scl_lo = ~r_q[1];
                if (w_last_q) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_scl_lo = (r_q == 2'd0);
                w_sda_lo = ~r_q[1];
                if (w_last_q) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_reset) begin
        if (iw_reset) begin
            r_div    <= 8'd0;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_wbyte  <= 8'd0;
            r_rx     <= 8'd0;
            r_rw     <= 1'b0;
            r_ack    <= 1'b0;
            or_busy  <= 1'b0;
            or_done  <= 1'b0;
            or_nack  <= 1'b0;
            or_rdata <= 8'h00;
        end else begin
            or_done <= 1'b0;
            if (w_accept) begin
                r_shift <= {iw_addr, iw_rw};
                r_rw    <= iw_rw;
                r_wbyte <= iw_wdata;
                r_div   <= 8'd0;
                r_q     <= 2'd0;
                r_bit   <= 3'd0;
                or_busy <= 1'b1;
                or_nack <= 1'b0;
            end else if (or_busy) begin
                r_div <= w_tick ? 8'd0 : r_div + 8'd1;
                if (w_tick) r_q <= r_q + 2'd1;
                // sda is sampled at the end of q2, mid-way through scl high
                if (w_tick && (r_q == 2'd2)) begin
                    case (r_state)
                        S_ADDR_ACK, S_WR_ACK: r_ack <= w_sda_in;
                        S_RD_DATA:            r_rx  <= {r_rx[6:0], w_sda_in};
                        default: ;
                    endcase
                end
                if (w_last_q) begin
                    case (r_state)
                        S_ADDR: begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_bit   <= r_bit + 3'd1;
                        end
                        S_WR_DATA: begin
                            r_wbyte <= {r_wbyte[6:0], 1'b0};
                            r_bit   <= r_bit + 3'd1;
                        end
                        S_RD_DATA: r_bit <= r_bit + 3'd1;
                        S_ADDR_ACK, S_WR_ACK: begin
                            if (r_ack) or_nack <= 1'b1;
                        end
                        S_RD_ACK: or_rdata <= r_rx;
                        S_STOP: begin
                            or_busy <= 1'b0;
                            or_done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C slave at address 7'h50
// and a bus monitor counting START/STOP conditions, scl rises and done pulses.
module tb_i2c_master_ctrl;

    localparam int D = 4;
    localparam logic [6:0] SLV = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, nack;
    logic [7:0] rdata;
    wire        scl, sda;

    pullup (scl);
    pullup (sda);

    logic s_drive = 1'b0;
    assign sda = s_drive ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .iw_clk   (clk),
        .iw_reset (rst),
        .iw_start (start),
        .iw_rw    (rw),
        .iw_addr  (addr),
        .iw_wdata (wdata),
        .or_busy  (busy),
        .or_done  (done),
        .or_rdata (rdata),
        .or_nack  (nack),
        .scl      (scl),
        .sda      (sda)
    );

    int tests = 0;
    int fails = 0;

    // slave model, oversampling the bus on the system clock
    typedef enum {P_IDLE, P_ADDR, P_AACK, P_WR, P_WACK, P_RD, P_RACK, P_DONE} ph_t;
    ph_t        ph = P_IDLE;
    logic [3:0] cnt = 4'd0;
    logic [7:0] sh = 8'd0;
    logic [7:0] s_stored = 8'h42;
    logic       s_rw = 1'b0;
    logic       s_mack = 1'b0;
    logic       s_load = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1, p_done = 1'b0;

    always @(posedge clk) begin
        p_scl <= scl;
        p_sda <= sda;
        if (s_load) s_stored <= 8'h42;
        if (rst) begin
            ph <= P_IDLE;
            s_drive <= 1'b0;
        end else if (p_scl && scl && p_sda && !sda) begin
            ph <= P_ADDR;
            cnt <= 4'd0;
            s_drive <= 1'b0;
        end else if (p_scl && scl && !p_sda && sda) begin
            ph <= P_IDLE;
            s_drive <= 1'b0;
        end else if (!p_scl && scl) begin
            case (ph)
                P_ADDR, P_WR: begin sh <= {sh[6:0], sda}; cnt <= cnt + 4'd1; end
                P_RD:   cnt <= cnt + 4'd1;
                P_RACK: begin s_mack <= sda; ph <= P_DONE; end
                default: ;
            endcase
        end else if (p_scl && !scl) begin
            case (ph)
                P_ADDR: if (cnt == 4'd8) begin
                    if (sh[7:1] == SLV) begin ph <= P_AACK; s_drive <= 1'b1; s_rw <= sh[0]; end
                    else ph <= P_DONE;
                end
                P_AACK: begin
                    cnt <= 4'd0;
                    if (s_rw) begin ph <= P_RD; s_drive <= ~s_stored[7]; end
                    else begin ph <= P_WR; s_drive <= 1'b0; end
                end
                P_WR: if (cnt == 4'd8) begin s_stored <= sh; ph <= P_WACK; s_drive <= 1'b1; end
                P_WACK: begin s_drive <= 1'b0; ph <= P_DONE; end
                P_RD: if (cnt == 4'd8) begin s_drive <= 1'b0; ph <= P_RACK; end
                      else s_drive <= ~s_stored[3'(4'd7 - cnt)];
                default: ;
            endcase
        end
    end

    // bus monitor: sda edges with scl high are START (falling) or STOP (rising)
    int n_start = 0, n_stop = 0, n_rise = 0, n_done = 0, n_wide = 0, n_bad = 0;
    always @(posedge clk) begin
        p_done <= done;
        if (p_scl && scl && (p_sda !== sda)) begin
            if (!sda) n_start <= n_start + 1;
            else      n_stop  <= n_stop + 1;
        end
        if (!p_scl && scl) n_rise <= n_rise + 1;
        if (done) n_done <= n_done + 1;
        if (done && p_done) n_wide <= n_wide + 1;
        if ((scl !== 1'b0 && scl !== 1'b1) || (sda !== 1'b0 && sda !== 1'b1)) n_bad <= n_bad + 1;
    end

    int lat1, trace1;

    task automatic issue(input logic rw_i, input logic [6:0] a_i, input logic [7:0] d_i,
                         input int coll, output int lat, output int trace, output logic busy1);
        @(negedge clk);
        start = 1'b1; rw = rw_i; addr = a_i; wdata = d_i;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        trace = 0;
        busy1 = busy;
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
            trace = {trace[30:0], trace[31]} ^ {30'd0, scl, sda};
            if (coll > 0 && lat == coll) begin
                start = 1'b1; addr = 7'h23; wdata = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (nack !== 1'b0) begin fails++; $display("FAIL reset_nack got %b want 0", nack); end
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", rdata); end
        tests++; if (scl !== 1'b1 || sda !== 1'b1) begin fails++; $display("FAIL reset_bus got %b%b want 11", scl, sda); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_ack;
        int lat, tr, r0, st0, sp0; logic b1;
        r0 = n_rise; st0 = n_start; sp0 = n_stop;
        issue(1'b1, SLV, 8'h00, 0, lat, tr, b1);
        tests++; if (lat !== 321) begin fails++; $display("FAIL read_latency got %0d want 321", lat); end
        tests++; if (rdata !== 8'h42) begin fails++; $display("FAIL read_rdata got %h want 42", rdata); end
        tests++; if (nack !== 1'b0) begin fails++; $display("FAIL read_nack got %b want 0", nack); end
        tests++; if (s_mack !== 1'b1) begin fails++; $display("FAIL read_master_nack got %b want 1", s_mack); end
        tests++; if (n_rise - r0 !== 19) begin fails++; $display("FAIL read_scl_rises got %0d want 19", n_rise - r0); end
        tests++; if (n_start - st0 !== 1 || n_stop - sp0 !== 1) begin
            fails++; $display("FAIL read_start_stop got %0d/%0d want 1/1", n_start - st0, n_stop - sp0); end
    endtask

    task automatic test_addr_nack;
        int lat, tr, r0, sp0; logic b1;
        r0 = n_rise; sp0 = n_stop;
        issue(1'b0, 7'h23, 8'h5A, 0, lat, tr, b1);
        tests++; if (lat !== 177) begin fails++; $display("FAIL nack_latency got %0d want 177", lat); end
        tests++; if (nack !== 1'b1) begin fails++; $display("FAIL nack_flag got %b want 1", nack); end
        tests++; if (rdata !== 8'h42) begin fails++; $display("FAIL nack_rdata got %h want 42", rdata); end
        tests++; if (n_rise - r0 !== 10) begin fails++; $display("FAIL nack_scl_rises got %0d want 10", n_rise - r0); end
        tests++; if (n_stop - sp0 !== 1) begin fails++; $display("FAIL nack_stop got %0d want 1", n_stop - sp0); end
    endtask

    task automatic test_write_ack;
        int lat, tr, r0, st0, sp0; logic b1;
        r0 = n_rise; st0 = n_start; sp0 = n_stop;
        issue(1'b0, SLV, 8'hA5, 0, lat, tr, b1);
        lat1 = lat; trace1 = tr;
        tests++; if (b1 !== 1'b1) begin fails++; $display("FAIL write_busy_rise got %b want 1", b1); end
        tests++; if (lat !== 321) begin fails++; $display("FAIL write_latency got %0d want 321", lat); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_fall got %b want 0", busy); end
        tests++; if (nack !== 1'b0) begin fails++; $display("FAIL write_nack got %b want 0", nack); end
        tests++; if (s_stored !== 8'hA5) begin fails++; $display("FAIL write_slave_data got %h want a5", s_stored); end
        tests++; if (n_rise - r0 !== 19) begin fails++; $display("FAIL write_scl_rises got %0d want 19", n_rise - r0); end
        tests++; if (n_start - st0 !== 1 || n_stop - sp0 !== 1) begin
            fails++; $display("FAIL write_start_stop got %0d/%0d want 1/1", n_start - st0, n_stop - sp0); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL write_done_width got %b want 0", done); end
    endtask

    task automatic test_busy_collision;
        int lat, tr, d0; logic b1;
        d0 = n_done;
        issue(1'b0, SLV, 8'hA5, 50, lat, tr, b1);
        repeat (100) @(negedge clk);
        tests++; if (lat !== 321) begin fails++; $display("FAIL coll_latency got %0d want 321", lat); end
        tests++; if (n_done - d0 !== 1) begin fails++; $display("FAIL coll_done_count got %0d want 1", n_done - d0); end
        tests++; if (tr !== trace1) begin fails++; $display("FAIL coll_trace got %h want %h", tr, trace1); end
        tests++; if (s_stored !== 8'hA5 || nack !== 1'b0) begin
            fails++; $display("FAIL coll_result got %h/%b want a5/0", s_stored, nack); end
    endtask

    task automatic test_reset_mid;
        int lat, tr; logic b1;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = SLV; wdata = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (16 * D + 1) @(negedge clk);
        tests++; if (scl !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL mid_in_addr got scl=%b busy=%b want 0/1", scl, busy); end
        #2 rst = 1'b1;
        #1;
        tests++; if (scl !== 1'b1 || sda !== 1'b1) begin fails++; $display("FAIL mid_bus_release got %b%b want 11", scl, sda); end
        tests++; if ({busy, done, nack, rdata} !== 11'd0) begin
            fails++; $display("FAIL mid_outputs got %b%b%b %h want all 0", busy, done, nack, rdata); end
        @(negedge clk);
        rst = 1'b0; s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        issue(1'b1, SLV, 8'h00, 0, lat, tr, b1);
        tests++; if (lat !== 321 || rdata !== 8'h42 || nack !== 1'b0) begin
            fails++; $display("FAIL mid_fresh_read got lat=%0d rdata=%h nack=%b want 321/42/0", lat, rdata, nack); end
    endtask

    task automatic test_protocol;
        tests++; if (n_wide !== 0) begin fails++; $display("FAIL proto_done_width got %0d wide pulses want 0", n_wide); end
        tests++; if (n_bad !== 0) begin fails++; $display("FAIL proto_bus_level got %0d bad samples want 0", n_bad); end
        // one START per transaction: read, nack, write, collision, aborted, fresh read
        tests++; if (n_start !== 6) begin fails++; $display("FAIL proto_starts got %0d want 6", n_start); end
    endtask

    initial begin
        test_reset();
        test_read_ack();
        test_addr_nack();
        test_write_ack();
        test_busy_collision();
        test_reset_mid();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-byte I2C master controller that sequences complete bus transactions on the open-drain scl/sda lines shared with i2c_slave instances. A host issues one command (7-bit address, R/W, write byte). The block generates START, address, data, ACK/NACK and STOP. It then returns the read byte and the ACK status with a one-cycle done pulse.

Parameters:
CLK_DIV, 4, iw_clk cycles per SCL quarter-period; legal range 2..255.

Ports:
iw_clk  input  1  system clock; all logic on posedge.
iw_reset  input  1  asynchronous active-high reset.
iw_start  input  1  command request; sampled only in IDLE.
iw_rw  input  1  0 = write byte to slave, 1 = read byte from slave.
iw_addr  input  7  target slave address.
iw_wdata  input  8  byte to write; ignored when iw_rw = 1.
or_busy  output  1  high from accept through end of STOP.
or_done  output  1  one-cycle pulse at transaction end.
or_rdata  output  8  byte read; updated only on successful read.
or_nack  output  1  1 if address or write-data phase got NACK; valid with or_done, held until next accept.
scl  inout  1  open-drain: drives 0 or z, never 1.
sda  inout  1  open-drain: drives 0 or z, never 1.

Behaviour:
- Reset (async, any state):
  - scl and sda released to z immediately.
  - or_busy = 0, or_done = 0, or_nack = 0, or_rdata = 8'h00.
  - State = IDLE, quarter counter and bit counter cleared.
  - Abandoning a transaction mid-bus is allowed; no STOP is generated.
- Quarter tick:
  - Divider counts 0..CLK_DIV-1 and produces a tick on terminal count.
  - Divider runs only while busy and restarts at 0 on accept.
- Accept:
  - Condition: IDLE and iw_start = 1 at posedge.
  - Latch {iw_addr, iw_rw} into a shift byte and iw_wdata into a data byte.
  - or_busy = 1 and or_nack = 0 from the next cycle.
  - iw_start while busy is ignored (no queueing).
- States: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP. Each state except IDLE spans 4 quarters per bit (q0..q3).
- START (1 bit-time): q0–q1 scl = z, sda = z; q2–q3 scl = z, sda = 0.
- Data bit timing (ADDR, WR_DATA, RD_DATA, and both ACK slots):
  - q0: scl = 0, sda updated.
  - q1: scl = 0.
  - q2–q3: scl = z.
  - sda sampled on the tick ending q2.
  - Bits are sent MSB first.
- ADDR: 8 bits {addr[6:0], rw} -> ADDR_ACK, where sda is released and sampled.
  - Sample 0 -> WR_DATA if rw = 0, RD_DATA if rw = 1.
  - Sample 1 -> or_nack = 1, go to STOP (no data phase).
- WR_DATA: 8 bits -> WR_ACK, where sda is released and sampled. Sample 1 sets or_nack = 1. Always go to STOP.
- RD_DATA: sda released; 8 samples shift MSB first.
- RD_ACK: master drives sda = z (NACK, single-byte read). The shifted byte is copied to or_rdata at the end of RD_ACK. Go to STOP.
- STOP (1 bit-time): q0 scl = 0, sda = 0; q1 scl = z, sda = 0; q2–q3 scl = z, sda = z.
- Completion:
  - On the tick ending STOP q3, go to IDLE.
  - or_done = 1 for exactly the next cycle; or_busy falls in that same cycle.
- Latency from the accept edge to or_done:
  - Full transaction (1 + 9 + 9 + 1 bit-times): 80*CLK_DIV + 1 cycles.
  - Address NACK (1 + 9 + 1 bit-times): 44*CLK_DIV + 1 cycles.
- sda changes only while scl is held low, except in START and STOP.
- No clock stretching, no arbitration-loss detection, no repeated START.

Test Plan:
1. Write with ACK. Setup: i2c_slave SLAVE_ADDRESS = 7'h50, pull-ups, CLK_DIV = 4. Stimulus: iw_addr = 7'h50, iw_rw = 0, iw_wdata = 8'hA5. Required: or_done exactly 321 cycles after accept, or_nack = 0, slave stored data = 8'hA5.
2. Read with ACK. Setup: slave STORED_DATA = 8'h42. Stimulus: iw_addr = 7'h50, iw_rw = 1. Required: or_rdata = 8'h42, or_nack = 0, final byte NACKed (sda = z in RD_ACK), STOP seen.
3. Address NACK. Stimulus: iw_addr = 7'h23, iw_rw = 0. Required: no data phase, or_done at 177 cycles, or_nack = 1, or_rdata unchanged.
4. Busy collision. Stimulus: second iw_start pulse 50 cycles into a transaction. Required: ignored; exactly one or_done; bus trace identical to scenario 1.
5. Reset mid-transaction. Stimulus: assert iw_reset during ADDR bit 3, between clock edges. Required: scl/sda = z in the same timestep; all outputs zero; a fresh scenario-2 command afterwards succeeds.
6. Protocol checker (all scenarios): sda never toggles while scl is high except at START/STOP; scl/sda never driven to 1; or_done is always exactly one cycle wide.
